// File: rtl/ru_pkg.sv
// Shared state encoding and default sizing for the read-update issue path.
package ru_pkg;

   localparam int RU_ADDRW     = 16;
   localparam int RU_WL        = 32;
   localparam int RU_CNTW      = 32;
   localparam int RU_MEM_LAT   = 2;
   localparam int RU_PIPEDEPTH = 3;
   // Issue to write-visible: memory read stages, RU pipe, one write stage.
   localparam int RU_INFLIGHT  = RU_MEM_LAT + RU_PIPEDEPTH + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ru_state_e;

endpackage

// File: rtl/ru_hazard_scheduler_if.sv
// Edge stream into the scheduler and issue bus out to the RU pipeline.
interface ru_hazard_scheduler_if
   import ru_pkg::*;
#(
   parameter int ADDRW = RU_ADDRW,
   parameter int WL    = RU_WL
);
   logic             in_valid;
   logic             in_ready;
   logic [ADDRW-1:0] in_addr;
   logic [WL-1:0]    in_value;
   logic             issue_valid;
   logic [ADDRW-1:0] issue_src;
   logic [WL-1:0]    issue_value;

   modport master (
      output in_valid, in_addr, in_value,
      input  in_ready,
      input  issue_valid, issue_src, issue_value
   );

   modport slave (
      input  in_valid, in_addr, in_value,
      output in_ready,
      output issue_valid, issue_src, issue_value
   );
endinterface

// File: rtl/ru_edge_fifo.sv
// Synchronous edge FIFO: a push is visible at head the next cycle; pushes while full are dropped,
// so the caller must gate push with !full (a pop does not free a slot in the same cycle).
module ru_edge_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 48
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign head  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full)
            wptr <= wptr + (AW+1)'(1);
         if (pop && !empty)
            rptr <= rptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/ru_hazard_scheduler.sv
// RU issue controller: FIFO head issues combinationally in the same cycle unless a RAW hazard
// or stallwrite holds it; upstream is backpressured through in_ready when the FIFO is full.
module ru_hazard_scheduler
   import ru_pkg::*;
#(
   parameter int ADDRW     = RU_ADDRW,
   parameter int WL        = RU_WL,
   parameter int INFLIGHT  = RU_INFLIGHT,
   parameter int FIFODEPTH = 4,
   parameter int CNTW      = RU_CNTW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CNTW-1:0]      num_edges,
   input  logic                 stallwrite,
   input  logic                 wb_valid,
   ru_hazard_scheduler_if.slave eif,
   output logic                 ru_ena,
   output logic                 busy,
   output logic                 done,
   output logic [CNTW-1:0]      hazard_cnt
);
   ru_state_e           state, state_nxt;
   logic [CNTW-1:0]     n_edges, accepted, completed, haz_q;
   logic                fifo_full, fifo_empty, push, advance, hazard, sb_busy;
   logic                in_rdy, issue_vld;
   logic [ADDRW+WL-1:0] head_dat;
   logic [ADDRW-1:0]    head_addr;
   logic [WL-1:0]       head_value;
   logic [INFLIGHT-1:0] sb_vld;
   logic [ADDRW-1:0]    sb_addr [INFLIGHT];

   ru_edge_fifo #(.DEPTH(FIFODEPTH), .W(ADDRW+WL)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (issue_vld),
      .din   ({eif.in_addr, eif.in_value}),
      .head  (head_dat),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_addr  = head_dat[ADDRW+WL-1:WL];
   assign head_value = head_dat[WL-1:0];

   // Outputs are forced quiet while reset is held, not only after it is sampled.
   assign ru_ena     = rst_n && (state == RUN || state == DRAIN);
   assign busy       = rst_n && (state != IDLE);
   assign done       = rst_n && (state == DONE);
   assign hazard_cnt = rst_n ? haz_q : '0;
   assign advance    = ru_ena && !stallwrite;
   assign in_rdy     = rst_n && (state == RUN) && !fifo_full && (accepted < n_edges);
   assign push       = eif.in_valid && in_rdy;
   assign issue_vld  = advance && !fifo_empty && !hazard;
   assign sb_busy    = |sb_vld;

   assign eif.in_ready    = in_rdy;
   assign eif.issue_valid = issue_vld;
   assign eif.issue_src   = issue_vld ? head_addr : '0;
   assign eif.issue_value = issue_vld ? head_value : '0;

   // The oldest entry is in its write cycle, and a read issued now already observes it.
   always_comb begin
      hazard = 1'b0;
      for (int k = 0; k < INFLIGHT-1; k++)
         if (sb_vld[k] && sb_addr[k] == head_addr)
            hazard = 1'b1;
      hazard = hazard && !fifo_empty;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (num_edges == '0) ? DRAIN : RUN;
         RUN:     if (accepted == n_edges) state_nxt = DRAIN;
         DRAIN:   if (fifo_empty && !sb_busy && completed == n_edges) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         n_edges   <= '0;
         accepted  <= '0;
         completed <= '0;
         haz_q     <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            n_edges   <= num_edges;
            accepted  <= '0;
            completed <= '0;
            haz_q     <= '0;
         end else begin
            if (push)
               accepted <= accepted + CNTW'(1);
            if (wb_valid && state != IDLE)
               completed <= completed + CNTW'(1);
            if (advance && hazard && haz_q != '1)
               haz_q <= haz_q + CNTW'(1);
         end
      end
   end

   // Shifts only on advance so it stays in step with the frozen RU pipeline.
   always_ff @(posedge clk) begin
      if (!rst_n)
         sb_vld <= '0;
      else if (advance)
         sb_vld <= {sb_vld[INFLIGHT-2:0], issue_vld};
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         sb_addr[0] <= eif.issue_src;
         for (int k = 1; k < INFLIGHT; k++)
            sb_addr[k] <= sb_addr[k-1];
      end
   end
endmodule
